fetch_queue: RTL and testbench

Instruction-fetch stage for the RV32IM single-issue core, sitting directly upstream of the combinational instruction memory and downstream of branch/jump resolution. Owns the fetch PC, drives the imem word address, captures each returned instruction word with its PC into a small prefetch FIFO, and presents them to decode over a valid/ready handshake. A redirect from execute flushes the queue and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 85 ++++++++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   XLEN             - architectural word width
//   fetch_entry_t    - one prefetch-queue entry: {pc, instr}
//   DEFAULT_RESET_PC - fetch address used after reset unless overridden
package fetch_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch_entry_t.
//   clk, reset_n  - clock, asynchronous active-low reset
//   push, wdata   - enqueue request and entry (ignored when full without pop)
//   pop           - dequeue the head (ignored when empty)
//   flush         - discard all entries; wins over push
//   rdata         - head entry, read from registered storage
//   count         - number of valid entries (0..DEPTH)
//   full, empty   - status flags derived from count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A push into a full queue is legal when the head leaves in the same cycle:
  // the tail slot being written is the one the head pointer is vacating.
  assign do_pop  = pop & !empty;
  assign do_push = push & !flush & (!full | do_pop);

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (do_push && !do_pop) begin
      count_next = count_reg + CW'(1);
    end else if (!do_push && do_pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Storage is reset so that the stale head seen while empty is never X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  assign rdata = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a prefetch FIFO.
//   clk, reset_n         - clock, asynchronous active-low reset
//   imem_addr            - word-aligned fetch address (registered fetch PC)
//   imem_rd              - instruction word returned combinationally by imem
//   redirect_valid/_pc   - flush the queue and restart fetch at redirect_pc
//   inst_valid/_ready    - handshake towards decode
//   inst_out, inst_pc    - head instruction and its PC
//   inst_pcplus4         - inst_pc + 4 (wrapping)
//   misalign_err         - sticky: a redirect target had non-zero [1:0]
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pcplus4,
  output logic            misalign_err
);

  logic [XLEN-1:0]        fpc_reg;
  logic [XLEN-1:0]        fpc_next;
  logic                   misalign_reg;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   count_unused;
  fetch_entry_t           wr_entry;
  fetch_entry_t           head;

  // Occupancy is fully captured by full/empty at this level.
  assign count_unused = ^count;

  assign pop  = inst_valid & inst_ready;
  // Nothing is fetched in a redirect cycle: imem_addr still shows the old path.
  assign push = !redirect_valid & (!full | pop);

  assign wr_entry.pc    = fpc_reg;
  assign wr_entry.instr = imem_rd;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wdata   (wr_entry),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    fpc_next = fpc_reg;
    if (redirect_valid) begin
      fpc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      fpc_next = fpc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_reg      <= RESET_PC;
      misalign_reg <= 1'b0;
    end else begin
      fpc_reg <= fpc_next;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misalign_reg <= 1'b1;
    end
  end

  assign imem_addr    = fpc_reg;
  assign misalign_err = misalign_reg;
  assign inst_valid   = !empty;
  assign inst_out     = head.instr;
  assign inst_pc      = head.pc;
  assign inst_pcplus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test of fetch_queue with a combinational imem model.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .inst_pcplus4   (inst_pcplus4),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the standard program plus an address-derived filler.
  function automatic logic [31:0] prog(input logic [31:0] a);
    case (a)
      32'h0000_0000: prog = 32'h0050_0113;
      32'h0000_0004: prog = 32'h00C0_0193;
      32'h0000_0008: prog = 32'h0231_03B3;
      32'h0000_0028: prog = 32'h0023_A233;
      default:       prog = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_rd = prog(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("  ok   %s = %h", tag, got);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] plus4);
    check_eq({tag, ".valid"}, 32'(inst_valid), 32'd1);
    check_eq({tag, ".pc"},    inst_pc,         pc);
    check_eq({tag, ".instr"}, inst_out,        instr);
    check_eq({tag, ".pc4"},   inst_pcplus4,    plus4);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset inside the current cycle (called just after an edge).
  task automatic apply_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("rst.valid", 32'(inst_valid), 32'd0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    @(posedge clk);
    #1;
    reset_n    = 1'b1;
    inst_ready = 1'b1;

    // Reset state, cycle 0
    check_eq("reset.addr",  imem_addr,             32'h0);
    check_eq("reset.valid", 32'(inst_valid),       32'd0);
    check_eq("reset.out",   inst_out,              32'h0);
    check_eq("reset.pc",    inst_pc,               32'h0);
    check_eq("reset.pc4",   inst_pcplus4,          32'h4);
    check_eq("reset.mis",   32'(misalign_err),     32'd0);

    // In-order streaming with ready high
    step(); check_head("s1.c1", 32'h0, 32'h0050_0113, 32'h4);
    step(); check_head("s1.c2", 32'h4, 32'h00C0_0193, 32'h8);
    step(); check_head("s1.c3", 32'h8, 32'h0231_03B3, 32'hC);

    // Backpressure: fill, freeze, release
    apply_reset();
    inst_ready = 1'b0;
    check_eq("s2.addr0", imem_addr, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_head($sformatf("s2.hold%0d", k), 32'h0, 32'h0050_0113, 32'h4);
      check_eq($sformatf("s2.addr%0d", k), imem_addr, (k == 1) ? 32'h4 : 32'h8);
    end
    inst_ready = 1'b1;
    step(); check_head("s2.rel1", 32'h4, 32'h00C0_0193, 32'h8);
    step(); check_head("s2.rel2", 32'h8, 32'h0231_03B3, 32'hC);
    step(); check_head("s2.rel3", 32'hC, 32'h5A5A_000C, 32'h10);

    // Redirect while full, no pop
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h28;
    step();
    check_eq("s3.valid", 32'(inst_valid), 32'd0);
    check_eq("s3.addr",  imem_addr,       32'h28);
    redirect_valid = 1'b0;
    step(); check_head("s3.t0", 32'h28, 32'h0023_A233, 32'h2C);
    inst_ready = 1'b1;
    step(); check_head("s3.t1", 32'h2C, 32'h5A5A_002C, 32'h30);
    step(); check_head("s3.t2", 32'h30, 32'h5A5A_0030, 32'h34);

    // Redirect coinciding with a pop of pc 0x4
    apply_reset();
    inst_ready = 1'b1;
    step(); check_head("s4.c1", 32'h0, 32'h0050_0113, 32'h4);
    step(); check_head("s4.c2", 32'h4, 32'h00C0_0193, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    check_eq("s4.valid", 32'(inst_valid), 32'd0);
    check_eq("s4.addr",  imem_addr,       32'h40);
    redirect_valid = 1'b0;
    step(); check_head("s4.t0", 32'h40, 32'h5A5A_0040, 32'h44);

    // Misaligned redirect, then asynchronous reset mid-stream
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2A;
    step();
    check_eq("s5.mis",   32'(misalign_err), 32'd1);
    check_eq("s5.addr",  imem_addr,         32'h28);
    check_eq("s5.valid", 32'(inst_valid),   32'd0);
    redirect_valid = 1'b0;
    step(); check_head("s5.t0", 32'h28, 32'h0023_A233, 32'h2C);
    check_eq("s5.mis1", 32'(misalign_err), 32'd1);
    step(); check_head("s5.t1", 32'h2C, 32'h5A5A_002C, 32'h30);
    check_eq("s5.mis2", 32'(misalign_err), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("s5.arst.valid", 32'(inst_valid),   32'd0);
    check_eq("s5.arst.mis",   32'(misalign_err), 32'd0);
    check_eq("s5.arst.addr",  imem_addr,         32'h0);
    #1;
    reset_n = 1'b1;

    // Back-to-back redirects, then PC wrap-around
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    check_eq("s6.valid0", 32'(inst_valid), 32'd0);
    check_eq("s6.addr0",  imem_addr,       32'h100);
    redirect_pc = 32'hFFFF_FFF8;
    step();
    check_eq("s6.valid1", 32'(inst_valid), 32'd0);
    check_eq("s6.addr1",  imem_addr,       32'hFFFF_FFF8);
    redirect_valid = 1'b0;
    step(); check_head("s6.w0", 32'hFFFF_FFF8, 32'hA5A5_FFF8, 32'hFFFF_FFFC);
    step(); check_head("s6.w1", 32'hFFFF_FFFC, 32'hA5A5_FFFC, 32'h0);
    step(); check_head("s6.w2", 32'h0, 32'h0050_0113, 32'h4);
    check_eq("s6.mis", 32'(misalign_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
